// File: rtl/writeback_regfile.sv
// ---------------------------------------------------------------------------
// writeback_regfile
//
// Write-back stage of a 5-stage MIPS-style pipeline fused with the 32x32
// register file it commits into. The MEM/WB instruction is decoded for its
// destination register. The result is written on the rising clock edge.
// The decode stage (IF/ID) reads rs/rt asynchronously and receives
// forwarding flags for a same-cycle write-back hit.
//
// Optional feature (macro RF_WRITE_BYPASS_EN):
//   defined     - read ports return MEMWBValue on a same-cycle destination
//                 match (write-before-read); IDEXAfromWB/IDEXBfromWB tied 0.
//   not defined - read ports return array contents only; flags report the
//                 same-cycle match so decode can forward.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   MEMWBIR          instruction in the MEM/WB latch
//   MEMWBValue       result to write back
//   IFIDIR           instruction in IF/ID (rs=[25:21], rt=[20:16])
//   rsData, rtData   register file read data for rs / rt
//   IDEXAfromWB      rs matches this cycle's write-back destination
//   IDEXBfromWB      rt matches this cycle's write-back destination
//   wbWrite, wbDest  combinational write enable / destination register
//   retiredCount     count of non-bubble instructions retired (wraps)
//   lastWrReg        last register written
//   lastWrData       last value written
// ---------------------------------------------------------------------------
module writeback_regfile #(
   parameter logic [31:0] NOOP_IR = 32'h0000_0020,
   parameter logic [5:0]  ALUOP   = 6'b000000,
   parameter logic [5:0]  LWOP    = 6'b100011,
   parameter logic [5:0]  ADDIOP  = 6'b001000,
   parameter int          CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [31:0]      MEMWBIR,
   input  logic [31:0]      MEMWBValue,
   input  logic [31:0]      IFIDIR,
   output logic [31:0]      rsData,
   output logic [31:0]      rtData,
   output logic             IDEXAfromWB,
   output logic             IDEXBfromWB,
   output logic             wbWrite,
   output logic [4:0]       wbDest,
   output logic [CNT_W-1:0] retiredCount,
   output logic [4:0]       lastWrReg,
   output logic [31:0]      lastWrData
);

   logic [5:0]       op;
   logic             dest_writer;
   logic [4:0]       if_rs;
   logic [4:0]       if_rt;
   logic [31:0]      rf_rs;
   logic [31:0]      rf_rt;
   logic             match_a;
   logic             match_b;

   logic [31:0]      regs_q [0:31];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       last_reg_q, last_reg_d;
   logic [31:0]      last_data_q, last_data_d;

   // Only the register specifiers of IF/ID are of interest here.
   logic             unused_ifid_bits;
   assign unused_ifid_bits = ^{IFIDIR[31:26], IFIDIR[15:0]};

   assign if_rs = IFIDIR[25:21];
   assign if_rt = IFIDIR[20:16];

   // Destination decode. Non-writing opcodes report r0, and writes to r0
   // are suppressed, which also covers the bubble encoding.
   always_comb begin
      op          = MEMWBIR[31:26];
      wbDest      = 5'd0;
      dest_writer = 1'b0;
      if (op == ALUOP) begin
         wbDest      = MEMWBIR[15:11];
         dest_writer = 1'b1;
      end else if ((op == LWOP) || (op == ADDIOP)) begin
         wbDest      = MEMWBIR[20:16];
         dest_writer = 1'b1;
      end
      wbWrite = dest_writer && (wbDest != 5'd0);
   end

   // Register array. Entry 0 is cleared by reset and never written; the
   // read mux also forces it to zero so r0 is safe before the first reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 32; i++) begin
            regs_q[i] <= '0;
         end
      end else if (wbWrite) begin
         regs_q[wbDest] <= MEMWBValue;
      end
   end

   assign rf_rs = (if_rs == 5'd0) ? 32'd0 : regs_q[if_rs];
   assign rf_rt = (if_rt == 5'd0) ? 32'd0 : regs_q[if_rt];

   // wbWrite already excludes r0, so neither match can fire for r0.
   assign match_a = wbWrite && (wbDest == if_rs);
   assign match_b = wbWrite && (wbDest == if_rt);

`ifdef RF_WRITE_BYPASS_EN
   assign rsData      = match_a ? MEMWBValue : rf_rs;
   assign rtData      = match_b ? MEMWBValue : rf_rt;
   assign IDEXAfromWB = 1'b0;
   assign IDEXBfromWB = 1'b0;
`else
   assign rsData      = rf_rs;
   assign rtData      = rf_rt;
   assign IDEXAfromWB = match_a;
   assign IDEXBfromWB = match_b;
`endif

   // Retirement counter and last-write trace.
   always_comb begin
      cnt_d       = cnt_q;
      last_reg_d  = last_reg_q;
      last_data_d = last_data_q;
      if (MEMWBIR != NOOP_IR) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
      if (wbWrite) begin
         last_reg_d  = wbDest;
         last_data_d = MEMWBValue;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q       <= '0;
         last_reg_q  <= '0;
         last_data_q <= '0;
      end else begin
         cnt_q       <= cnt_d;
         last_reg_q  <= last_reg_d;
         last_data_q <= last_data_d;
      end
   end

   assign retiredCount = cnt_q;
   assign lastWrReg    = last_reg_q;
   assign lastWrData   = last_data_q;

endmodule

// File: tb/tb_writeback_regfile.sv
module tb_writeback_regfile;

   localparam logic [31:0] NOOP = 32'h0000_0020;

   logic        clk;
   logic        reset;
   logic [31:0] MEMWBIR;
   logic [31:0] MEMWBValue;
   logic [31:0] IFIDIR;

   logic [31:0] rsData, rtData;
   logic        IDEXAfromWB, IDEXBfromWB, wbWrite;
   logic [4:0]  wbDest, lastWrReg;
   logic [31:0] retiredCount, lastWrData;

   logic [31:0] s_rsData, s_rtData;
   logic        s_flagA, s_flagB, s_wbWrite;
   logic [4:0]  s_wbDest, s_lastWrReg;
   logic [3:0]  s_retiredCount;
   logic [31:0] s_lastWrData;

   int errors = 0;
   int checks = 0;

   // Reference model state
   logic [31:0] m_regs [32];
   logic [31:0] m_cnt;
   logic [3:0]  m_cnt4;
   logic [4:0]  m_last_reg;
   logic [31:0] m_last_data;
   logic [31:0] exp_q [$];

   writeback_regfile dut (
      .clk(clk), .reset(reset), .MEMWBIR(MEMWBIR), .MEMWBValue(MEMWBValue),
      .IFIDIR(IFIDIR), .rsData(rsData), .rtData(rtData),
      .IDEXAfromWB(IDEXAfromWB), .IDEXBfromWB(IDEXBfromWB),
      .wbWrite(wbWrite), .wbDest(wbDest), .retiredCount(retiredCount),
      .lastWrReg(lastWrReg), .lastWrData(lastWrData)
   );

   // Narrow-counter instance sharing all inputs, used for the wrap check.
   writeback_regfile #(.CNT_W(4)) dut4 (
      .clk(clk), .reset(reset), .MEMWBIR(MEMWBIR), .MEMWBValue(MEMWBValue),
      .IFIDIR(IFIDIR), .rsData(s_rsData), .rtData(s_rtData),
      .IDEXAfromWB(s_flagA), .IDEXBfromWB(s_flagB),
      .wbWrite(s_wbWrite), .wbDest(s_wbDest), .retiredCount(s_retiredCount),
      .lastWrReg(s_lastWrReg), .lastWrData(s_lastWrData)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model helpers ----------------
   function automatic logic [4:0] m_dest(input logic [31:0] ir);
      case (ir[31:26])
         6'b000000:            return ir[15:11];
         6'b100011, 6'b001000: return ir[20:16];
         default:              return 5'd0;
      endcase
   endfunction

   // A write happens only for a writing opcode that targets a nonzero reg.
   function automatic logic m_wr(input logic [31:0] ir);
      return m_dest(ir) != 5'd0;
   endfunction

   function automatic logic m_flag(input logic [4:0] r);
`ifdef RF_WRITE_BYPASS_EN
      return 1'b0;
`else
      return m_wr(MEMWBIR) && (m_dest(MEMWBIR) == r);
`endif
   endfunction

   function automatic logic [31:0] m_read(input logic [4:0] r);
      logic [31:0] v;
      v = m_regs[r];
`ifdef RF_WRITE_BYPASS_EN
      if (m_wr(MEMWBIR) && (m_dest(MEMWBIR) == r)) v = MEMWBValue;
`endif
      return v;
   endfunction

   function automatic logic [31:0] mk_ir(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [4:0] rd);
      return {op, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   function automatic logic [31:0] mk_if(input logic [4:0] rs, input logic [4:0] rt);
      return {6'b000000, rs, rt, 16'h0820};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic drive(input logic rst, input logic [31:0] ir,
                        input logic [31:0] val, input logic [31:0] ifid);
      @(negedge clk);
      reset      = rst;
      MEMWBIR    = ir;
      MEMWBValue = val;
      IFIDIR     = ifid;
      #1;
   endtask

   // Advance one clock edge and update the model from the driven inputs.
   task automatic tick();
      logic       wr;
      logic [4:0] d;
      wr = m_wr(MEMWBIR);
      d  = m_dest(MEMWBIR);
      @(posedge clk);
      if (reset) begin
         for (int i = 0; i < 32; i++) m_regs[i] = '0;
         m_cnt = '0; m_cnt4 = '0; m_last_reg = '0; m_last_data = '0;
      end else begin
         if (wr) begin
            m_regs[d]   = MEMWBValue;
            m_last_reg  = d;
            m_last_data = MEMWBValue;
         end
         if (MEMWBIR != NOOP) begin
            m_cnt  = m_cnt + 1;
            m_cnt4 = m_cnt4 + 4'd1;
         end
      end
      #1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      drive(1'b1, NOOP, 32'h0, mk_if(5'd5, 5'd7));
      tick();
      checks++;
      if (retiredCount !== 32'd0) begin errors++; $display("FAIL reset_cnt: got %0d want 0", retiredCount); end
      checks++;
      if (lastWrReg !== 5'd0 || lastWrData !== 32'd0) begin
         errors++; $display("FAIL reset_last: got r%0d %h want r0 0", lastWrReg, lastWrData);
      end
      checks++;
      if (rsData !== 32'd0 || rtData !== 32'd0) begin
         errors++; $display("FAIL reset_regs: got %h %h want 0 0", rsData, rtData);
      end
      checks++;
      if (s_retiredCount !== 4'd0) begin errors++; $display("FAIL reset_cnt4: got %0d want 0", s_retiredCount); end
   endtask

   task automatic test_alu_write();
      drive(1'b0, mk_ir(6'b000000, 5'd1, 5'd2, 5'd5), 32'h1234_5678, mk_if(5'd5, 5'd0));
      checks++;
      if (wbWrite !== 1'b1 || wbDest !== 5'd5) begin
         errors++; $display("FAIL alu_decode: got wr=%b dest=%0d want wr=1 dest=5", wbWrite, wbDest);
      end
      checks++;
      if (IDEXAfromWB !== m_flag(5'd5) || IDEXBfromWB !== 1'b0) begin
         errors++; $display("FAIL alu_flags: got %b%b want %b0", IDEXAfromWB, IDEXBfromWB, m_flag(5'd5));
      end
      tick();
      drive(1'b0, NOOP, 32'h0, mk_if(5'd5, 5'd0));
      checks++;
      if (rsData !== 32'h1234_5678) begin errors++; $display("FAIL alu_read: got %h want 12345678", rsData); end
      checks++;
      if (lastWrReg !== 5'd5 || lastWrData !== 32'h1234_5678) begin
         errors++; $display("FAIL alu_last: got r%0d %h want r5 12345678", lastWrReg, lastWrData);
      end
      tick();
   endtask

   task automatic test_load_collision();
      logic [31:0] e_rt;
      drive(1'b0, mk_ir(6'b100011, 5'd1, 5'd7, 5'd0), 32'hDEAD_BEEF, mk_if(5'd7, 5'd7));
      e_rt = m_read(5'd7);
      checks++;
      if (IDEXAfromWB !== m_flag(5'd7) || IDEXBfromWB !== m_flag(5'd7)) begin
         errors++; $display("FAIL lw_flags: got %b%b want %b%b", IDEXAfromWB, IDEXBfromWB, m_flag(5'd7), m_flag(5'd7));
      end
      checks++;
      if (rtData !== e_rt) begin errors++; $display("FAIL lw_same_cycle: got %h want %h", rtData, e_rt); end
      tick();
      drive(1'b0, NOOP, 32'h0, mk_if(5'd7, 5'd7));
      checks++;
      if (rtData !== 32'hDEAD_BEEF || rsData !== 32'hDEAD_BEEF) begin
         errors++; $display("FAIL lw_next: got %h %h want deadbeef", rsData, rtData);
      end
      tick();
   endtask

   task automatic test_r0();
      drive(1'b0, mk_ir(6'b000000, 5'd3, 5'd4, 5'd0), 32'hFFFF_FFFF, mk_if(5'd0, 5'd0));
      checks++;
      if (wbWrite !== 1'b0 || IDEXAfromWB !== 1'b0 || IDEXBfromWB !== 1'b0 || rsData !== 32'd0) begin
         errors++; $display("FAIL r0_same: got wr=%b fl=%b%b rs=%h want 0 00 0", wbWrite, IDEXAfromWB, IDEXBfromWB, rsData);
      end
      tick();
      drive(1'b0, NOOP, 32'h0, mk_if(5'd0, 5'd0));
      checks++;
      if (rsData !== 32'd0 || lastWrReg !== 5'd7) begin
         errors++; $display("FAIL r0_next: got rs=%h last=r%0d want 0 r7", rsData, lastWrReg);
      end
      tick();
   endtask

   task automatic test_nonwriters();
      logic [31:0] base;
      logic [31:0] ir_list [5];
      ir_list[0] = {6'b101011, 5'd5, 5'd7, 16'h0004}; // sw
      ir_list[1] = {6'b000100, 5'd5, 5'd7, 16'h0008}; // beq
      ir_list[2] = NOOP; ir_list[3] = NOOP; ir_list[4] = NOOP;
      base = m_cnt;
      exp_q.push_back(m_regs[5]);
      exp_q.push_back(m_regs[7]);
      for (int i = 0; i < 5; i++) begin
         drive(1'b0, ir_list[i], 32'hA5A5_0000 | i, mk_if(5'd5, 5'd7));
         checks++;
         if (wbWrite !== 1'b0) begin errors++; $display("FAIL nw_write[%0d]: got %b want 0", i, wbWrite); end
         tick();
      end
      drive(1'b0, NOOP, 32'h0, mk_if(5'd5, 5'd7));
      checks++;
      if (retiredCount !== base + 32'd2) begin
         errors++; $display("FAIL nw_count: got %0d want %0d", retiredCount, base + 32'd2);
      end
      checks++;
      if (rsData !== exp_q.pop_front()) begin errors++; $display("FAIL nw_r5: got %h", rsData); end
      checks++;
      if (rtData !== exp_q.pop_front()) begin errors++; $display("FAIL nw_r7: got %h", rtData); end
      tick();
   endtask

   task automatic test_reset_mid();
      logic [31:0] addi9;
      addi9 = {6'b001000, 5'd0, 5'd9, 16'h0055};
      drive(1'b1, addi9, 32'h55, mk_if(5'd9, 5'd5));
      tick();
      checks++;
      if (rsData !== 32'd0 || rtData !== 32'd0) begin
         errors++; $display("FAIL rmid_regs: got %h %h want 0 0", rsData, rtData);
      end
      checks++;
      if (retiredCount !== 32'd0 || lastWrData !== 32'd0) begin
         errors++; $display("FAIL rmid_state: got cnt=%0d last=%h want 0 0", retiredCount, lastWrData);
      end
      drive(1'b0, addi9, 32'h55, mk_if(5'd9, 5'd0));
      tick();
      checks++;
      if (rsData !== 32'h55 || retiredCount !== 32'd1 || lastWrReg !== 5'd9) begin
         errors++; $display("FAIL rmid_resume: got rs=%h cnt=%0d last=r%0d want 55 1 r9", rsData, retiredCount, lastWrReg);
      end
   endtask

   task automatic test_counter_wrap();
      drive(1'b1, NOOP, 32'h0, mk_if(5'd0, 5'd0));
      tick();
      for (int i = 0; i < 17; i++) begin
         drive(1'b0, {6'b101011, 5'd1, 5'd2, 16'h0000}, 32'h0, mk_if(5'd0, 5'd0));
         tick();
      end
      checks++;
      if (s_retiredCount !== 4'd1) begin errors++; $display("FAIL wrap_cnt4: got %0d want 1", s_retiredCount); end
      checks++;
      if (retiredCount !== 32'd17) begin errors++; $display("FAIL wrap_cnt32: got %0d want 17", retiredCount); end
   endtask

   task automatic test_random();
      logic [31:0] ir, val, ifid;
      logic [4:0]  rs, rt;
      logic        rst;
      logic [5:0]  ops [7];
      ops[0] = 6'b000000; ops[1] = 6'b100011; ops[2] = 6'b001000;
      ops[3] = 6'b101011; ops[4] = 6'b000100; ops[5] = 6'b111111; ops[6] = 6'b000000;
      for (int n = 0; n < 300; n++) begin
         // Small register range makes collisions and r0 targets frequent.
         ir = {ops[$urandom_range(0, 6)], 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 7)), 11'($urandom)};
         if ($urandom_range(0, 7) == 0) ir = NOOP;
         val  = $urandom;
         rs   = 5'($urandom_range(0, 7));
         rt   = 5'($urandom_range(0, 7));
         ifid = mk_if(rs, rt);
         rst  = ($urandom_range(0, 49) == 0);
         drive(rst, ir, val, ifid);
         checks++;
         if (wbWrite !== m_wr(ir) || wbDest !== m_dest(ir)) begin
            errors++; $display("FAIL rnd_decode[%0d]: got %b/%0d want %b/%0d", n, wbWrite, wbDest, m_wr(ir), m_dest(ir));
         end
         checks++;
         if (IDEXAfromWB !== m_flag(rs) || IDEXBfromWB !== m_flag(rt)) begin
            errors++; $display("FAIL rnd_flags[%0d]: got %b%b want %b%b", n, IDEXAfromWB, IDEXBfromWB, m_flag(rs), m_flag(rt));
         end
         checks++;
         if (rsData !== m_read(rs) || rtData !== m_read(rt)) begin
            errors++; $display("FAIL rnd_read[%0d]: got %h %h want %h %h", n, rsData, rtData, m_read(rs), m_read(rt));
         end
         tick();
         checks++;
         if (retiredCount !== m_cnt || s_retiredCount !== m_cnt4) begin
            errors++; $display("FAIL rnd_count[%0d]: got %0d/%0d want %0d/%0d", n, retiredCount, s_retiredCount, m_cnt, m_cnt4);
         end
         checks++;
         if (lastWrReg !== m_last_reg || lastWrData !== m_last_data) begin
            errors++; $display("FAIL rnd_last[%0d]: got r%0d %h want r%0d %h", n, lastWrReg, lastWrData, m_last_reg, m_last_data);
         end
      end
   endtask

   // ---------------- sequence and report ----------------
   initial begin
      reset = 1'b1; MEMWBIR = NOOP; MEMWBValue = '0; IFIDIR = '0;
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_cnt = '0; m_cnt4 = '0; m_last_reg = '0; m_last_data = '0;
      test_reset();
      test_alu_write();
      test_load_collision();
      test_r0();
      test_nonwriters();
      test_reset_mid();
      test_counter_wrap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/writeback_regfile.md
Name: writeback_regfile

Overview:
- Write-back stage of the 5-stage MIPS-style pipeline, paired with the register file it writes.
- Consumes the MEM/WB instruction and result, decodes the destination register, and commits the result to a 32x32 register file on the clock edge.
- Supplies the decode stage with rs/rt read data and the IDEXAfromWB/IDEXBfromWB forwarding flags for the instruction currently in IF/ID.
- Keeps retirement bookkeeping for debug and performance.

Parameters:
- NOOP_IR, 32'h0000_0020, pipeline bubble encoding (add r0,r0,r0); never counted as retired.
- ALUOP, 6'b000000, R-type opcode; destination rd = IR[15:11].
- LWOP, 6'b100011, load word; destination rt = IR[20:16].
- ADDIOP, 6'b001000, add immediate; destination rt = IR[20:16].
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  synchronous, active-high reset.
- MEMWBIR  in  32  instruction in the MEM/WB latch.
- MEMWBValue  in  32  result to write back (ALU result or load data).
- IFIDIR  in  32  instruction in IF/ID; source of rs = [25:21] and rt = [20:16].
- rsData  out  32  register file value at IFIDIR[25:21].
- rtData  out  32  register file value at IFIDIR[20:16].
- IDEXAfromWB  out  1  rs of IFIDIR matches the WB destination this cycle.
- IDEXBfromWB  out  1  rt of IFIDIR matches the WB destination this cycle.
- wbWrite  out  1  combinational write enable for the current MEMWBIR.
- wbDest  out  5  combinational destination register for the current MEMWBIR.
- retiredCount  out  CNT_W  count of non-bubble instructions retired.
- lastWrReg  out  5  registered: last register written.
- lastWrData  out  32  registered: last value written.

Behaviour:
- Destination decode (combinational):
  - op = MEMWBIR[31:26].
  - ALUOP: wbDest = MEMWBIR[15:11].
  - LWOP or ADDIOP: wbDest = MEMWBIR[20:16].
  - Any other opcode (SW, BEQ, unknown): wbDest = 0, wbWrite = 0.
  - wbWrite = 1 only when op is ALUOP, LWOP or ADDIOP and wbDest != 0.
  - The NOOP_IR encoding targets r0, so a bubble gives wbWrite = 0.
- Register file:
  - 32 entries x 32 bits. r0 always reads 0 and is never written.
  - Write at posedge clk when wbWrite && !reset: Regs[wbDest] <= MEMWBValue.
- Read ports:
  - Combinational and asynchronous from the array.
  - A write in cycle N is visible on rsData/rtData from cycle N+1.
  - Same-cycle data is covered by the forwarding flags.
- Forwarding flags (combinational):
  - IDEXAfromWB = wbWrite && (wbDest == IFIDIR[25:21]).
  - IDEXBfromWB = wbWrite && (wbDest == IFIDIR[20:16]).
  - Both flags assert together when rs == rt == wbDest.
  - r0 never asserts a flag.
- Retirement:
  - At posedge, when !reset and MEMWBIR != NOOP_IR, retiredCount increments by 1.
  - retiredCount wraps modulo 2^CNT_W.
  - SW and BEQ count as retired even though they do not write.
- Last-write trace:
  - When a write occurs, lastWrReg <= wbDest and lastWrData <= MEMWBValue.
  - Otherwise both hold their values.
- Reset (synchronous):
  - All 32 registers, retiredCount, lastWrReg and lastWrData go to 0 on the clock edge where reset = 1.
  - No write or increment occurs in a reset cycle, even if wbWrite = 1.
  - The combinational outputs still reflect their inputs during reset. Decode ignores them because the stall/no_op path flushes the pipeline.
- Reset mid-stream: the first instruction with reset low is processed normally, with no residual state from before reset.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN.
- Defined:
  - rsData/rtData return MEMWBValue when the corresponding (pre-gating) match condition holds, giving write-before-read semantics.
  - IDEXAfromWB and IDEXBfromWB are tied to 0, so decode never selects its own forwarding mux.
- Not defined: read ports return array contents only, and the flags behave as described in Behaviour.

Test Plan:
- Reset then ALU write: reset 1 cycle, then MEMWBIR = add r5,r1,r2 (rd=5) with MEMWBValue = 32'h1234_5678. wbWrite = 1, wbDest = 5. Next cycle IFIDIR rs=5 gives rsData = 32'h1234_5678 and lastWrReg = 5.
- Load / forward collision: MEMWBIR = lw r7 (rt=7) with MEMWBValue = 32'hDEAD_BEEF, IFIDIR rs=7, rt=7. IDEXAfromWB = IDEXBfromWB = 1 in the same cycle; rtData shows the old value (0) until the next edge.
- r0 protection: MEMWBIR = add r0,r3,r4 with MEMWBValue = 32'hFFFF_FFFF, IFIDIR rs=0. wbWrite = 0, no flags, rsData = 0; the next cycle is still 0.
- Non-writers and bubbles: issue SW, BEQ, then 3x NOOP_IR. No register changes; retiredCount rises by exactly 2.
- Reset mid-operation: assert reset on a cycle where MEMWBIR = addi r9 with value 32'h55. r9 stays 0, retiredCount = 0 and lastWrData = 0 after the edge.
- Counter wrap: with CNT_W = 4, retire 17 non-bubble instructions. retiredCount = 1.
